// File: rtl/imem_fetch_ctrl_if.sv
// imem_fetch_ctrl_if: decode handshake, redirect, memory port and loader signals of the fetch controller
// master: the fetch controller; slave: decode, memory and loader side.
// FETCH_PERF_EN: adds the perf_fetch/perf_stall counter outputs.
interface imem_fetch_ctrl_if;
  logic        iready;
  logic        ivalid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_ack;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;
`endif
  modport master (
    input  iready, redirect, redirect_pc, mem_rdata, ld_req, ld_addr, ld_data,
`ifdef FETCH_PERF_EN
    output perf_fetch, perf_stall,
`endif
    output ivalid, instr_out, pc_out, mem_addr, mem_we, mem_wdata, ld_ack
  );
  modport slave (
    output iready, redirect, redirect_pc, mem_rdata, ld_req, ld_addr, ld_data,
`ifdef FETCH_PERF_EN
    input  perf_fetch, perf_stall,
`endif
    input  ivalid, instr_out, pc_out, mem_addr, mem_we, mem_wdata, ld_ack
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction fetch sequencer with a 2-entry return queue, sharing the memory port with a loader
// Ports: clk; rst_n (async, active-low); bus (imem_fetch_ctrl_if.master) carrying the decode
//   handshake (ivalid/iready/instr_out/pc_out), redirect/redirect_pc, the memory port
//   (mem_addr/mem_we/mem_wdata/mem_rdata) and the loader (ld_req/ld_addr/ld_data/ld_ack).
// FETCH_PERF_EN: when defined, drives the perf_fetch/perf_stall counters on bus.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 256
) (
  input logic               clk,
  input logic               rst_n,
  imem_fetch_ctrl_if.master bus
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic {RUN, LOAD} state_t;
  state_t      state, state_n;
  logic [1:0]  cnt, cnt_n;
  logic [31:0] q_d [2];
  logic [31:0] q_p [2];
  logic [31:0] q_d_n [2];
  logic [31:0] q_p_n [2];
  logic        inflight, inflight_n;
  logic [31:0] if_pc, if_pc_n, fetch_pc, fetch_pc_n;
  logic        pop;
  logic [2:0]  occ;
  assign bus.ivalid    = state == RUN && cnt != 2'd0;
  assign bus.instr_out = q_d[0];
  assign bus.pc_out    = q_p[0];
  assign bus.mem_addr  = state == LOAD ? bus.ld_addr : fetch_pc;
  assign bus.mem_we    = state == LOAD && bus.ld_req;
  assign bus.ld_ack    = state == LOAD && bus.ld_req;
  assign bus.mem_wdata = bus.ld_data;
  assign pop = bus.ivalid && bus.iready;
  // slots that will be occupied after this edge, counting the read already in flight
  assign occ = 3'(cnt) + 3'(inflight) - 3'(pop);
  always_comb begin
    state_n    = state;
    cnt_n      = cnt - 2'(pop);
    q_d_n      = q_d;
    q_p_n      = q_p;
    inflight_n = 1'b0;
    if_pc_n    = if_pc;
    fetch_pc_n = fetch_pc;
    if (pop) begin
      q_d_n[0] = q_d[1];
      q_p_n[0] = q_p[1];
    end
    if (state == LOAD) begin
      if (!bus.ld_req) begin
        state_n    = RUN;
        cnt_n      = 2'd0;
        fetch_pc_n = RESET_PC;
      end
    end else if (bus.ld_req) begin
      state_n = LOAD;
    end else if (bus.redirect) begin
      cnt_n      = 2'd0;
      fetch_pc_n = bus.redirect_pc & ~32'd3;
    end else begin
      // occupancy never exceeds 2, so after the pop the tail slot is 0 or 1
      if (inflight) begin
        q_d_n[cnt_n[0]] = if_pc[31:2] >= 30'(IMEM_WORDS) ? NOP : bus.mem_rdata;
        q_p_n[cnt_n[0]] = if_pc;
        cnt_n           = cnt_n + 2'd1;
      end
      if (occ < 3'd2) begin
        inflight_n = 1'b1;
        if_pc_n    = fetch_pc;
        fetch_pc_n = fetch_pc + 32'd4;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      cnt      <= 2'd0;
      q_d      <= '{NOP, NOP};
      q_p      <= '{RESET_PC, RESET_PC};
      inflight <= 1'b0;
      if_pc    <= RESET_PC;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      q_d      <= q_d_n;
      q_p      <= q_p_n;
      inflight <= inflight_n;
      if_pc    <= if_pc_n;
      fetch_pc <= fetch_pc_n;
    end
  end
`ifdef FETCH_PERF_EN
  // pop implies RUN, so a RUN cycle without a pop is a stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.perf_fetch <= '0;
      bus.perf_stall <= '0;
    end else if (state == LOAD && !bus.ld_req) begin
      bus.perf_fetch <= '0;
      bus.perf_stall <= '0;
    end else begin
      bus.perf_fetch <= bus.perf_fetch + 32'(pop);
      bus.perf_stall <= bus.perf_stall + 32'(state == RUN && !pop);
    end
  end
`endif
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: randomized fetch/redirect/load traffic checked against an in-order instruction stream model
module tb_imem_fetch_ctrl;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          IMEM_WORDS = 256;
  localparam logic [31:0] NOP        = 32'h0000_0013;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  imem_fetch_ctrl_if bus();
  imem_fetch_ctrl #(.RESET_PC(RESET_PC), .IMEM_WORDS(IMEM_WORDS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_vec = 0;
  int n_err = 0;
  int pops = 0;
  bit in_load = 0;
  bit redir_prev = 0;
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] ref_mem [IMEM_WORDS];
  logic [31:0] mem [IMEM_WORDS];
  // synchronous memory: one-cycle registered read, out-of-range reads return garbage
  initial begin
    for (int i = 0; i < IMEM_WORDS; i++) mem[i] = 32'(i);
    forever begin
      @(posedge clk);
      if (bus.mem_we && bus.mem_addr[31:2] < 30'(IMEM_WORDS)) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      bus.mem_rdata <= bus.mem_addr[31:2] < 30'(IMEM_WORDS) ? mem[bus.mem_addr[9:2]] : 32'hDEAD_BEEF;
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_instr(input logic [31:0] pc);
    return pc[31:2] < 30'(IMEM_WORDS) ? ref_mem[pc[9:2]] : NOP;
  endfunction
  // drive one cycle of inputs after the falling edge, then check what decode sees this cycle
  task automatic tick(input logic rdy, input logic rd, input logic [31:0] rpc,
                      input logic lreq, input logic [31:0] laddr, input logic [31:0] ldata);
    @(negedge clk);
    bus.iready = rdy;
    bus.redirect = rd;
    bus.redirect_pc = rpc;
    bus.ld_req = lreq;
    bus.ld_addr = laddr;
    bus.ld_data = ldata;
    #1;
    if (redir_prev) chk("redir_flush", 32'(bus.ivalid), 0);
    if (bus.ivalid) chk("lookahead", 32'(bus.mem_addr - bus.pc_out <= 32'd8), 1);
    if (bus.ivalid && bus.iready) begin
      chk("pop_pc", bus.pc_out, exp_pc);
      chk("pop_instr", bus.instr_out, ref_instr(exp_pc));
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    redir_prev = rd && !lreq && !in_load;
    if (redir_prev) exp_pc = rpc & ~32'd3;
  endtask
  task automatic idle(input logic rdy);
    tick(rdy, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask
  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ivalid", 32'(bus.ivalid), 0);
    chk("rst_instr", bus.instr_out, NOP);
    chk("rst_pc", bus.pc_out, RESET_PC);
    chk("rst_ld_ack", 32'(bus.ld_ack), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    bus.iready = 1'b0;
    bus.redirect = 1'b0;
    bus.ld_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_pc = RESET_PC;
    in_load = 0;
    redir_prev = 0;
    pops = 0;
  endtask
  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    do begin
      idle(1'b0);
      n++;
    end while (!bus.ivalid && n < 8);
    chk(tag, 32'(bus.ivalid), 1);
  endtask
  // first request cycle is still RUN (no ack); each later cycle commits one word
  task automatic load(input logic [31:0] base, input int n, input logic [31:0] d0, input bit abort);
    int w;
    in_load = 1;
    for (int i = 0; i <= n; i++) begin
      w = i == 0 ? 0 : i - 1;
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'b1, base + 32'(4 * w), d0 + 32'(w));
      chk("ld_ack", 32'(bus.ld_ack), 32'(i != 0));
      chk("ld_mem_we", 32'(bus.mem_we), 32'(i != 0));
      if (i != 0) chk("ld_ivalid", 32'(bus.ivalid), 0);
      if (i != 0 && bus.mem_addr != base + 32'(4 * w)) chk("ld_addr", bus.mem_addr, base + 32'(4 * w));
      if (abort && i == 2) begin
        apply_reset();
        return;
      end
      if (i != 0) ref_mem[base[9:2] + 8'(w)] = d0 + 32'(w);
    end
    idle(1'b1);
    chk("ld_exit_ack", 32'(bus.ld_ack), 0);
    in_load = 0;
    exp_pc = RESET_PC;
    pops = 0;
  endtask
  initial begin
    int r, s;
    logic [31:0] t, h_pc, h_in;
    for (int i = 0; i < IMEM_WORDS; i++) ref_mem[i] = 32'(i);
    bus.iready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.ld_req = 1'b0;
    bus.ld_addr = 32'h0;
    bus.ld_data = 32'h0;
    apply_reset();
    // first word after the second edge, then one per cycle
    idle(1'b1);
    chk("lat_edge1", 32'(bus.ivalid), 0);
    idle(1'b1);
    chk("lat_edge2", 32'(bus.ivalid), 1);
    chk("first_pc", bus.pc_out, RESET_PC);
    idle(1'b1);
    chk("tput_1", 32'(bus.ivalid), 1);
    idle(1'b1);
    chk("tput_2", 32'(bus.ivalid), 1);
    // decode stall
    idle(1'b0);
    h_pc = bus.pc_out;
    h_in = bus.instr_out;
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      chk("stall_valid", 32'(bus.ivalid), 1);
      chk("stall_pc", bus.pc_out, h_pc);
      chk("stall_instr", bus.instr_out, h_in);
    end
    repeat (4) idle(1'b1);
    // redirect with a read in flight
    tick(1'b1, 1'b1, 32'h41, 1'b0, 32'h0, 32'h0);
    idle(1'b1);
    idle(1'b1);
    chk("redir_gap", 32'(bus.ivalid), 0);
    idle(1'b1);
    chk("redir_valid", 32'(bus.ivalid), 1);
    chk("redir_pc", bus.pc_out, 32'h40);
    repeat (3) idle(1'b1);
    // loader writes A,B,C then fetch restarts
    load(32'h0, 3, 32'hA, 1'b0);
    wait_valid("ld_restart_valid");
    chk("ld_restart_pc", bus.pc_out, RESET_PC);
    chk("ld_restart_instr", bus.instr_out, 32'hA);
    repeat (3) idle(1'b1);
    // end of memory and address wrap
    tick(1'b0, 1'b1, 32'(4 * (IMEM_WORDS - 1)), 1'b0, 32'h0, 32'h0);
    wait_valid("top_valid");
    chk("top_pc", bus.pc_out, 32'(4 * (IMEM_WORDS - 1)));
    chk("top_instr", bus.instr_out, ref_mem[IMEM_WORDS - 1]);
    idle(1'b1);
    wait_valid("oor_valid");
    chk("oor_instr", bus.instr_out, NOP);
    tick(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
    wait_valid("wrap_valid");
    chk("wrap_top_instr", bus.instr_out, NOP);
    idle(1'b1);
    wait_valid("wrap0_valid");
    chk("wrap0_pc", bus.pc_out, 32'h0);
    chk("wrap0_instr", bus.instr_out, 32'hA);
    // asynchronous reset during a load burst, then during a stall
    load(32'h20, 3, 32'h5000, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("rst1_valid", 32'(bus.ivalid), 1);
    repeat (3) idle(1'b0);
    apply_reset();
    idle(1'b1);
    chk("rst2_edge1", 32'(bus.ivalid), 0);
    idle(1'b1);
    chk("rst2_edge2", 32'(bus.ivalid), 1);
    // random traffic
    for (int c = 0; c < 2000; c++) begin
      r = $urandom_range(0, 999);
      s = $urandom_range(0, 2);
      if (r < 4) begin
        load(32'(4 * $urandom_range(0, IMEM_WORDS - 5)), $urandom_range(1, 4), $urandom, 1'b0);
      end else if (r < 50) begin
        t = s == 0 ? ($urandom & 32'h0000_07FF)
          : s == 1 ? 32'(4 * $urandom_range(IMEM_WORDS - 3, IMEM_WORDS + 1)) + 32'($urandom_range(0, 3))
          : 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
        tick(1'($urandom_range(0, 1)), 1'b1, t, 1'b0, 32'h0, 32'h0);
      end else begin
        idle($urandom_range(0, 3) != 0);
      end
    end
    idle(1'b0);
`ifdef FETCH_PERF_EN
    chk("perf_fetch", bus.perf_fetch, 32'(pops));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
